// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
//   pll_state_e : sequencer states
//   COUNT_W     : width of the debug event counters
//   cnt_width() : width of the shared dwell counter for a given set of limits
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned COUNT_W = 8;

  // One counter serves every state, so size it for the longest dwell limit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single-bit asynchronous input.
//   i_clk : destination clock
//   i_rst : synchronous active-high reset, clears all stages
//   i_d   : asynchronous input
//   o_q   : i_d delayed through STAGES flops
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer, clocked by the board reference clock.
// Pulses the PLL active-low reset, waits for a synchronized and stable LOCK,
// then releases the system reset. Retries on lock timeout, re-enters reset on
// lock loss, and keeps saturating counts of both events.
//   clk_i           : reference clock
//   rst_i           : synchronous active-high reset
//   pll_lock_i      : PLL LOCK, asynchronous to clk_i
//   pll_resetb_o    : PLL RESETB, active low
//   rst_o           : active-high system reset
//   ready_o         : high only while running
//   relock_count_o  : saturating count of lock losses while running
//   timeout_count_o : saturating count of lock-wait timeouts
module pll_reset_seq
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned PLL_RESET_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pll_lock_i,
  output logic               pll_resetb_o,
  output logic               rst_o,
  output logic               ready_o,
  output logic [COUNT_W-1:0] relock_count_o,
  output logic [COUNT_W-1:0] timeout_count_o
);

  localparam int unsigned CNT_W =
    cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  pll_state_e          r_state;
  pll_state_e          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_lock_s;
  logic                w_timeout_evt;
  logic                w_relock_evt;
  logic                r_pll_resetb;
  logic                r_rst;
  logic                r_ready;
  logic [COUNT_W-1:0]  r_relock_cnt;
  logic [COUNT_W-1:0]  r_timeout_cnt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (pll_lock_i),
    .o_q   (w_lock_s)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_timeout_evt = 1'b0;
    w_relock_evt  = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == RST_LAST) w_state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (w_lock_s) begin
          w_state_nxt = STABLE;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt   = PLL_RST;
          w_timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt  = PLL_RST;
          w_relock_evt = 1'b1;
        end
      end
      default: w_state_nxt = PLL_RST;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  // Outputs are decoded from the next state and registered, so they change
  // on the same edge as the state register and cannot glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= PLL_RST;
      r_cnt         <= '0;
      r_pll_resetb  <= 1'b0;
      r_rst         <= 1'b1;
      r_ready       <= 1'b0;
      r_relock_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pll_resetb <= (w_state_nxt != PLL_RST);
      r_rst        <= (w_state_nxt != RUN);
      r_ready      <= (w_state_nxt == RUN);
      if (w_relock_evt && (r_relock_cnt != '1)) begin
        r_relock_cnt <= r_relock_cnt + 1'b1;
      end
      if (w_timeout_evt && (r_timeout_cnt != '1)) begin
        r_timeout_cnt <= r_timeout_cnt + 1'b1;
      end
    end
  end

  assign pll_resetb_o    = r_pll_resetb;
  assign rst_o           = r_rst;
  assign ready_o         = r_ready;
  assign relock_count_o  = r_relock_cnt;
  assign timeout_count_o = r_timeout_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with a behavioural reference model.
module tb_pll_reset_seq;

  localparam int SYNC = 2;
  localparam int PRC  = 4;
  localparam int LTC  = 32;
  localparam int LSC  = 8;

  localparam int PH_PRST = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;

  logic       clk        = 1'b0;
  logic       rst_i      = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       pll_resetb_o;
  logic       rst_o;
  logic       ready_o;
  logic [7:0] relock_count_o;
  logic [7:0] timeout_count_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES         (SYNC),
    .PLL_RESET_CYCLES    (PRC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .pll_lock_i      (pll_lock_i),
    .pll_resetb_o    (pll_resetb_o),
    .rst_o           (rst_o),
    .ready_o         (ready_o),
    .relock_count_o  (relock_count_o),
    .timeout_count_o (timeout_count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase plus time-spent-in-phase; lock_s is the input as it was SYNC edges ago.
  int ph     = PH_PRST;
  int dwell  = 0;
  int tcnt   = 0;
  int rcnt   = 0;
  bit hist[SYNC];
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    bit ls;
    if (rst_i) begin
      ph     = PH_PRST;
      dwell  = 0;
      tcnt   = 0;
      rcnt   = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      mvalid = 1'b1;
    end else begin
      ls = hist[SYNC-1];
      case (ph)
        PH_PRST: begin
          if (dwell + 1 >= PRC) begin ph = PH_WAIT; dwell = 0; end
          else dwell++;
        end
        PH_WAIT: begin
          if (ls) begin ph = PH_STAB; dwell = 0; end
          else if (dwell + 1 >= LTC) begin
            ph = PH_PRST; dwell = 0;
            if (tcnt < 255) tcnt++;
          end else dwell++;
        end
        PH_STAB: begin
          if (!ls) begin ph = PH_WAIT; dwell = 0; end
          else if (dwell + 1 >= LSC) begin ph = PH_RUN; dwell = 0; end
          else dwell++;
        end
        default: begin
          if (!ls) begin
            ph = PH_PRST; dwell = 0;
            if (rcnt < 255) rcnt++;
          end
        end
      endcase
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pll_lock_i;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("pll_resetb_o", 32'(pll_resetb_o), 32'(ph != PH_PRST));
      check("rst_o", 32'(rst_o), 32'(ph != PH_RUN));
      check("ready_o", 32'(ready_o), 32'(ph == PH_RUN));
      check("relock_count_o", 32'(relock_count_o), 32'(rcnt));
      check("timeout_count_o", 32'(timeout_count_o), 32'(tcnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return pll_resetb_o;
      1: return rst_o;
      default: return ready_o;
    endcase
  endfunction

  // Wait (bounded) until the selected output equals val; an expired bound fails.
  task automatic wait_until(input int which, input logic val, input int limit, input string name);
    int k;
    k = 0;
    while (sel(which) !== val && k < limit) begin
      cyc(1);
      k++;
    end
    check(name, 32'(sel(which)), 32'(val));
  endtask

  // Cycles from now until the selected output equals val (bounded).
  task automatic count_until(input int which, input logic val, input int limit, output int k);
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (sel(which) !== val && k < limit);
  endtask

  // Cycles (including now) that the selected output keeps value val.
  task automatic count_while(input int which, input logic val, input int limit, output int k);
    k = 0;
    while (sel(which) === val && k < limit) begin
      k++;
      cyc(1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int seg;
    // Power-up reset, lock held low
    rst_i = 1'b1; pll_lock_i = 1'b0;
    cyc(3);
    check("reset_resetb", 32'(pll_resetb_o), 32'd0);
    check("reset_rst_o", 32'(rst_o), 32'd1);
    check("reset_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b0;
    count_while(0, 1'b0, 20, k);
    check("powerup_pll_reset_cycles", 32'(k), 32'd4);

    // Timeout loops
    count_until(0, 1'b0, 100, k);
    check("wait_lock_cycles_to_timeout", 32'(k), 32'd32);
    check("timeout_count_first", 32'(timeout_count_o), 32'd1);
    count_while(0, 1'b0, 20, k);
    check("timeout_pll_reset_cycles", 32'(k), 32'd4);
    cyc(70);
    check("timeout_count_three", 32'(timeout_count_o), 32'd3);
    check("model_timeout_count_three", 32'(tcnt), 32'd3);

    // Clean lock after a fresh reset
    rst_i = 1'b1; cyc(2); rst_i = 1'b0;
    check("timeout_count_cleared", 32'(timeout_count_o), 32'd0);
    wait_until(0, 1'b1, 20, "clean_wait_resetb_high");
    cyc(5);
    pll_lock_i = 1'b1;
    count_until(2, 1'b1, 60, k);
    check("clean_lock_latency", 32'(k), 32'd11);
    check("clean_rst_o_low", 32'(rst_o), 32'd0);
    check("clean_relock_zero", 32'(relock_count_o), 32'd0);

    // Lock loss in RUN
    pll_lock_i = 1'b0;
    count_until(1, 1'b1, 20, k);
    check("run_loss_latency", 32'(k), 32'd3);
    check("run_loss_resetb", 32'(pll_resetb_o), 32'd0);
    check("run_loss_ready", 32'(ready_o), 32'd0);
    check("run_loss_relock_one", 32'(relock_count_o), 32'd1);

    // Chatter in STABLE
    wait_until(0, 1'b1, 20, "chatter_wait_resetb_high");
    pll_lock_i = 1'b1; cyc(5);
    pll_lock_i = 1'b0; cyc(2);
    pll_lock_i = 1'b1;
    count_until(2, 1'b1, 60, k);
    check("chatter_rerise_latency", 32'(k), 32'd11);
    check("chatter_relock_still_one", 32'(relock_count_o), 32'd1);

    // Relock saturation: 259 more losses, 260 in total
    for (int i = 0; i < 259; i++) begin
      pll_lock_i = 1'b0;
      wait_until(1, 1'b1, 20, "sat_wait_rst_o");
      wait_until(0, 1'b1, 20, "sat_wait_resetb");
      pll_lock_i = 1'b1;
      wait_until(2, 1'b1, 60, "sat_wait_ready");
    end
    check("relock_saturated", 32'(relock_count_o), 32'd255);
    check("model_relock_saturated", 32'(rcnt), 32'd255);

    // Reset mid-STABLE
    pll_lock_i = 1'b0;
    wait_until(1, 1'b1, 20, "mid_wait_rst_o");
    wait_until(0, 1'b1, 20, "mid_wait_resetb");
    pll_lock_i = 1'b1; cyc(5);
    rst_i = 1'b1; cyc(1);
    check("mid_reset_resetb", 32'(pll_resetb_o), 32'd0);
    check("mid_reset_rst_o", 32'(rst_o), 32'd1);
    check("mid_reset_relock", 32'(relock_count_o), 32'd0);
    check("mid_reset_timeout", 32'(timeout_count_o), 32'd0);
    rst_i = 1'b0;
    count_while(0, 1'b0, 20, k);
    check("mid_reset_pll_reset_cycles", 32'(k), 32'd4);

    // Randomized lock behaviour with occasional resets
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 25) == 0) begin
        rst_i = 1'b1;
        cyc($urandom_range(1, 3));
        rst_i = 1'b0;
      end
      pll_lock_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) seg = $urandom_range(1, 3);
      else seg = $urandom_range(4, 60);
      cyc(seg);
    end
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sequences the iCE40 PLL primitive wrapper: drives the PLL's active-low reset, watches its asynchronous LOCK output, and generates the system reset for logic clocked by the PLL output.
- Runs on the board reference clock, never on the PLL output, so it keeps working while the PLL is unlocked.
- Retries the PLL on lock timeout, re-asserts system reset on lock loss, and counts both events for debug.

Parameters:
- SYNC_STAGES, 2: flops in the pll_lock_i synchronizer; minimum 2.
- PLL_RESET_CYCLES, 16: cycles pll_resetb_o is held low per PLL reset pulse; minimum 1.
- LOCK_TIMEOUT_CYCLES, 65536: cycles spent in WAIT_LOCK before the PLL is reset again; minimum 1.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release; minimum 1.

Ports:
- clk_i, input, 1: reference clock (same net feeding the PLL REFERENCECLK).
- rst_i, input, 1: synchronous, active-high reset.
- pll_lock_i, input, 1: PLL LOCK output, asynchronous to clk_i.
- pll_resetb_o, output, 1: PLL RESETB, active low.
- rst_o, output, 1: active-high system reset; consumers re-synchronize it into the PLL clock domain.
- ready_o, output, 1: high only in RUN.
- relock_count_o, output, 8: saturating count of lock losses observed in RUN.
- timeout_count_o, output, 8: saturating count of WAIT_LOCK timeouts.

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is synchronous and active-high. All state updates on the rising edge of clk_i.
- Reset values, next edge with rst_i high:
  - state = PLL_RST, cnt = 0, synchronizer flops = 0.
  - pll_resetb_o = 0, rst_o = 1, ready_o = 0.
  - relock_count_o = 0, timeout_count_o = 0.
- Synchronizer: lock_s is pll_lock_i delayed through SYNC_STAGES flops. The FSM uses only lock_s.
- State-derived outputs: pll_resetb_o = (state != PLL_RST), rst_o = (state != RUN), ready_o = (state == RUN). All are registered state decodes and glitch-free.
- cnt: a single shared counter, $clog2(max of PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES) + 1 bits, cleared on every state transition.
- PLL_RST:
  - If cnt == PLL_RESET_CYCLES-1, go to WAIT_LOCK; otherwise cnt++.
  - lock_s is ignored in this state.
- WAIT_LOCK:
  - If lock_s == 1, go to STABLE.
  - Else if cnt == LOCK_TIMEOUT_CYCLES-1, go to PLL_RST and increment timeout_count_o.
  - Else cnt++.
  - If lock_s rises on the timeout cycle, the lock wins: go to STABLE, no timeout counted.
- STABLE:
  - If lock_s == 0, go to WAIT_LOCK; the timeout window restarts from 0.
  - Else if cnt == LOCK_STABLE_CYCLES-1, go to RUN.
  - Else cnt++.
- RUN:
  - If lock_s == 0, go to PLL_RST and increment relock_count_o.
  - rst_o rises and ready_o falls on that same edge.
- Latency: if lock_s is first high in WAIT_LOCK at cycle t, STABLE holds from t+1 and RUN (rst_o=0) from t+1+LOCK_STABLE_CYCLES. The pll_lock_i to lock_s delay is SYNC_STAGES cycles.
- Counters: 8-bit, saturate at 255, never wrap; cleared only by rst_i.
- Reset mid-operation: rst_i asserted in any state restarts a full PLL_RESET_CYCLES pulse; there is no partial resume.
- A lock glitch shorter than one clk_i period may be missed. This is acceptable: it is caught only if it spans a sampling edge.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the FSM state typedef enum {PLL_RST, WAIT_LOCK, STABLE, RUN}, 2-bit;
  - the counter width function/constant;
  - the count width localparam (8).
- Sub-module sync_ff (parameter STAGES): a generic multi-flop synchronizer for pll_lock_i, reusable elsewhere.
- Top level pll_clk_rst (follow-on): instantiates pll_reset_seq plus the PLL wrapper variant exposing RESETB and LOCK.

Test Plan (SYNC_STAGES=2, PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8):
- Power-up: rst_i high 3 cycles then low, pll_lock_i held 0 → pll_resetb_o low exactly 4 cycles after release, then high; rst_o=1, ready_o=0 throughout.
- Clean lock: pll_lock_i rises 5 cycles into WAIT_LOCK and stays high → ready_o rises and rst_o falls exactly 2+1+8=11 cycles after the pll_lock_i edge; counters stay 0.
- Timeout: pll_lock_i held 0 → after 32 WAIT_LOCK cycles, pll_resetb_o pulses low for 4 cycles, timeout_count_o=1; after 3 loops it reads 3.
- Chatter: in STABLE, drop pll_lock_i for 2 cycles at stable count 5 → return to WAIT_LOCK, no RUN; after re-rise, RUN comes a full 8 STABLE cycles later.
- Lock loss in RUN: drop pll_lock_i → 3 cycles later (2 sync + 1) rst_o=1, ready_o=0, pll_resetb_o=0, relock_count_o=1; repeat 260 times → relock_count_o saturates at 255.
- Reset mid-STABLE: assert rst_i → next edge state PLL_RST, both counters 0, full 4-cycle PLL reset pulse follows.
